// File: rtl/pipe_front_regs_if.sv
// pipe_front_regs_if: hazard strobes, fetch/decode inputs and pipeline register outputs of the front-end.
//   master: hazard unit / fetch / decode side (drives strobes, InstrF, CtrlD, operands)
//   slave : pipe_front_regs (drives PCF, IF/ID, ID/EX and counter outputs)
interface pipe_front_regs_if;
  logic        StallF, StallD, FlushD, FlushE, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [9:0]  CtrlD;
  logic [31:0] RD1D, RD2D, ImmExtD;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        ValidD, ValidE;
  logic [9:0]  CtrlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [31:0] StallCnt, FlushCnt;
  modport master (
    output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF, CtrlD, RD1D, RD2D, ImmExtD,
    input  PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD, ValidE, CtrlE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, StallCnt, FlushCnt
  );
  modport slave (
    input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF, CtrlD, RD1D, RD2D, ImmExtD,
    output PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD, ValidE, CtrlE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC, IF/ID and ID/EX pipeline registers with stall/flush/redirect control.
//   clk, rst_n (sync, active-low); bus: pipe_front_regs_if.slave carrying hazard strobes,
//   fetch/decode inputs and PCF / IF-ID / ID-EX / counter outputs.
//   Optional macro PIPE_PERF_CNT_EN adds saturating StallCnt/FlushCnt; otherwise both read 0.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic clk,
  input logic rst_n,
  pipe_front_regs_if.slave bus
);
  logic [31:0] pcf_q, pcf_d, pcplus4f;
  logic [31:0] instrd_q, instrd_d, pcd_q, pcd_d, pcplus4d_q, pcplus4d_d;
  logic        validd_q, validd_d, valide_q, valide_d;
  logic [9:0]  ctrle_q, ctrle_d;
  logic [31:0] rd1e_q, rd1e_d, rd2e_q, rd2e_d, immexte_q, immexte_d, pce_q, pce_d, pcplus4e_q, pcplus4e_d;
  logic [4:0]  rs1e_q, rs1e_d, rs2e_q, rs2e_d, rde_q, rde_d;
  always_comb begin
    pcplus4f   = pcf_q + 32'd4;
    pcf_d      = bus.PCSrcE ? bus.PCTargetE : bus.StallF ? pcf_q : pcplus4f;
    instrd_d   = bus.FlushD ? NOP_INSTR : bus.StallD ? instrd_q   : bus.InstrF;
    pcd_d      = bus.FlushD ? '0        : bus.StallD ? pcd_q      : pcf_q;
    pcplus4d_d = bus.FlushD ? '0        : bus.StallD ? pcplus4d_q : pcplus4f;
    validd_d   = bus.FlushD ? 1'b0      : bus.StallD ? validd_q   : 1'b1;
    ctrle_d    = bus.FlushE ? '0 : bus.CtrlD;
    rd1e_d     = bus.FlushE ? '0 : bus.RD1D;
    rd2e_d     = bus.FlushE ? '0 : bus.RD2D;
    immexte_d  = bus.FlushE ? '0 : bus.ImmExtD;
    pce_d      = bus.FlushE ? '0 : pcd_q;
    pcplus4e_d = bus.FlushE ? '0 : pcplus4d_q;
    rs1e_d     = bus.FlushE ? '0 : instrd_q[19:15];
    rs2e_d     = bus.FlushE ? '0 : instrd_q[24:20];
    rde_d      = bus.FlushE ? '0 : instrd_q[11:7];
    valide_d   = !bus.FlushE && validd_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcf_q      <= RESET_PC;
      instrd_q   <= NOP_INSTR;
      pcd_q      <= '0;
      pcplus4d_q <= '0;
      validd_q   <= 1'b0;
      valide_q   <= 1'b0;
      ctrle_q    <= '0;
      rd1e_q     <= '0;
      rd2e_q     <= '0;
      immexte_q  <= '0;
      pce_q      <= '0;
      pcplus4e_q <= '0;
      rs1e_q     <= '0;
      rs2e_q     <= '0;
      rde_q      <= '0;
    end else begin
      pcf_q      <= pcf_d;
      instrd_q   <= instrd_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
      valide_q   <= valide_d;
      ctrle_q    <= ctrle_d;
      rd1e_q     <= rd1e_d;
      rd2e_q     <= rd2e_d;
      immexte_q  <= immexte_d;
      pce_q      <= pce_d;
      pcplus4e_q <= pcplus4e_d;
      rs1e_q     <= rs1e_d;
      rs2e_q     <= rs2e_d;
      rde_q      <= rde_d;
    end
  end
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stallcnt_q, stallcnt_d, flushcnt_q, flushcnt_d;
  // A stall overridden by a flush is not a stall; a flush counts only when it kills a valid instruction.
  always_comb begin
    stallcnt_d = (bus.StallD && !bus.FlushD && stallcnt_q != '1) ? stallcnt_q + 32'd1 : stallcnt_q;
    flushcnt_d = (bus.FlushE && validd_q && flushcnt_q != '1) ? flushcnt_q + 32'd1 : flushcnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallcnt_q <= '0;
      flushcnt_q <= '0;
    end else begin
      stallcnt_q <= stallcnt_d;
      flushcnt_q <= flushcnt_d;
    end
  end
  assign bus.StallCnt = stallcnt_q;
  assign bus.FlushCnt = flushcnt_q;
`else
  assign bus.StallCnt = '0;
  assign bus.FlushCnt = '0;
`endif
  assign bus.PCF      = pcf_q;
  assign bus.InstrD   = instrd_q;
  assign bus.PCD      = pcd_q;
  assign bus.PCPlus4D = pcplus4d_q;
  assign bus.Rs1D     = instrd_q[19:15];
  assign bus.Rs2D     = instrd_q[24:20];
  assign bus.RdD      = instrd_q[11:7];
  assign bus.ValidD   = validd_q;
  assign bus.ValidE   = valide_q;
  assign bus.CtrlE    = ctrle_q;
  assign bus.RD1E     = rd1e_q;
  assign bus.RD2E     = rd2e_q;
  assign bus.ImmExtE  = immexte_q;
  assign bus.PCE      = pce_q;
  assign bus.PCPlus4E = pcplus4e_q;
  assign bus.Rs1E     = rs1e_q;
  assign bus.Rs2E     = rs2e_q;
  assign bus.RdE      = rde_q;
endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs: directed checks of PC, IF/ID and ID/EX registers under stall, flush, redirect and reset.
module tb_pipe_front_regs;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA  = {7'd0, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33};
  localparam logic [31:0] IB  = {7'd0, 5'd6, 5'd5, 3'd0, 5'd4, 7'h33};
  localparam logic [31:0] IC  = {7'd0, 5'd9, 5'd8, 3'd0, 5'd7, 7'h33};
  localparam logic [9:0]  CA  = 10'h2A5;
  localparam logic [9:0]  CB  = 10'h15A;
`ifdef PIPE_PERF_CNT_EN
  localparam logic [31:0] SC1 = 32'd1, FC1 = 32'd2, SC3 = 32'd3, FC3 = 32'd1;
`else
  localparam logic [31:0] SC1 = 32'd0, FC1 = 32'd0, SC3 = 32'd0, FC3 = 32'd0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total = 0;
  pipe_front_regs_if bus();
  pipe_front_regs dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic ctl(input logic sf, input logic sd, input logic fd, input logic fe, input logic pc, input logic [31:0] tgt);
    bus.StallF = sf;
    bus.StallD = sd;
    bus.FlushD = fd;
    bus.FlushE = fe;
    bus.PCSrcE = pc;
    bus.PCTargetE = tgt;
  endtask
  initial begin
    rst_n = 1'b0;
    ctl(0, 0, 0, 0, 0, 32'h0);
    bus.InstrF = IA;
    bus.CtrlD = CA;
    bus.RD1D = 32'h11;
    bus.RD2D = 32'h22;
    bus.ImmExtD = 32'h33;
    tick;
    chk("rst_pcf", bus.PCF, 32'h0);
    chk("rst_instrd", bus.InstrD, NOP);
    chk("rst_validd", {31'd0, bus.ValidD}, 32'd0);
    chk("rst_valide", {31'd0, bus.ValidE}, 32'd0);
    chk("rst_ctrle", {22'd0, bus.CtrlE}, 32'd0);
    chk("rst_stallcnt", bus.StallCnt, 32'd0);
    chk("rst_flushcnt", bus.FlushCnt, 32'd0);
    rst_n = 1'b1;
    bus.CtrlD = 10'd0;
    tick;
    chk("c1_pcf", bus.PCF, 32'h4);
    chk("c1_instrd", bus.InstrD, IA);
    chk("c1_rs1d", {27'd0, bus.Rs1D}, 32'd2);
    chk("c1_rs2d", {27'd0, bus.Rs2D}, 32'd3);
    chk("c1_rdd", {27'd0, bus.RdD}, 32'd1);
    chk("c1_pcplus4d", bus.PCPlus4D, 32'h4);
    chk("c1_validd", {31'd0, bus.ValidD}, 32'd1);
    bus.InstrF = IB;
    bus.CtrlD = CA;
    tick;
    chk("c2_pcf", bus.PCF, 32'h8);
    chk("c2_instrd", bus.InstrD, IB);
    chk("c2_ctrle", {22'd0, bus.CtrlE}, {22'd0, CA});
    chk("c2_rd1e", bus.RD1E, 32'h11);
    chk("c2_immexte", bus.ImmExtE, 32'h33);
    chk("c2_rs1e", {27'd0, bus.Rs1E}, 32'd2);
    chk("c2_rde", {27'd0, bus.RdE}, 32'd1);
    chk("c2_pcplus4e", bus.PCPlus4E, 32'h4);
    chk("c2_valide", {31'd0, bus.ValidE}, 32'd1);
    ctl(1, 1, 0, 1, 0, 32'h0);
    bus.InstrF = IC;
    bus.CtrlD = CB;
    tick;
    chk("stall_pcf", bus.PCF, 32'h8);
    chk("stall_instrd", bus.InstrD, IB);
    chk("stall_valide", {31'd0, bus.ValidE}, 32'd0);
    chk("stall_ctrle", {22'd0, bus.CtrlE}, 32'd0);
    chk("stall_rde", {27'd0, bus.RdE}, 32'd0);
    ctl(0, 0, 0, 0, 0, 32'h0);
    bus.RD1D = 32'h44;
    tick;
    chk("unstall_pcf", bus.PCF, 32'hC);
    chk("unstall_instrd", bus.InstrD, IC);
    chk("unstall_ctrle", {22'd0, bus.CtrlE}, {22'd0, CB});
    chk("unstall_rde", {27'd0, bus.RdE}, 32'd4);
    chk("unstall_pce", bus.PCE, 32'h4);
    chk("unstall_rd1e", bus.RD1E, 32'h44);
    chk("unstall_valide", {31'd0, bus.ValidE}, 32'd1);
    ctl(1, 0, 1, 1, 1, 32'h0000_0100);
    tick;
    chk("redir_pcf", bus.PCF, 32'h100);
    chk("redir_instrd", bus.InstrD, NOP);
    chk("redir_pcd", bus.PCD, 32'h0);
    chk("redir_pcplus4d", bus.PCPlus4D, 32'h0);
    chk("redir_validd", {31'd0, bus.ValidD}, 32'd0);
    chk("redir_valide", {31'd0, bus.ValidE}, 32'd0);
    chk("redir_ctrle", {22'd0, bus.CtrlE}, 32'd0);
    ctl(0, 0, 0, 0, 0, 32'h0);
    bus.InstrF = IA;
    bus.CtrlD = 10'd0;
    tick;
    chk("post_redir_pcf", bus.PCF, 32'h104);
    chk("post_redir_pcd", bus.PCD, 32'h100);
    chk("post_redir_valide", {31'd0, bus.ValidE}, 32'd0);
    ctl(1, 1, 1, 0, 0, 32'h0);
    tick;
    chk("flushwin_pcf", bus.PCF, 32'h104);
    chk("flushwin_instrd", bus.InstrD, NOP);
    chk("flushwin_validd", {31'd0, bus.ValidD}, 32'd0);
    chk("flushwin_valide", {31'd0, bus.ValidE}, 32'd1);
    ctl(0, 0, 1, 1, 1, 32'hFFFF_FFFC);
    tick;
    chk("wrap_pre_pcf", bus.PCF, 32'hFFFF_FFFC);
    ctl(0, 0, 0, 0, 0, 32'h0);
    bus.InstrF = IB;
    tick;
    chk("wrap_pcf", bus.PCF, 32'h0);
    chk("wrap_pcd", bus.PCD, 32'hFFFF_FFFC);
    chk("wrap_pcplus4d", bus.PCPlus4D, 32'h0);
    chk("pre_rst_stallcnt", bus.StallCnt, SC1);
    chk("pre_rst_flushcnt", bus.FlushCnt, FC1);
    rst_n = 1'b0;
    ctl(1, 1, 0, 1, 1, 32'h200);
    bus.CtrlD = CB;
    tick;
    chk("rst_stall_pcf", bus.PCF, 32'h0);
    chk("rst_stall_instrd", bus.InstrD, NOP);
    chk("rst_stall_validd", {31'd0, bus.ValidD}, 32'd0);
    chk("rst_stall_valide", {31'd0, bus.ValidE}, 32'd0);
    chk("rst_stall_ctrle", {22'd0, bus.CtrlE}, 32'd0);
    chk("rst_stall_stallcnt", bus.StallCnt, 32'd0);
    chk("rst_stall_flushcnt", bus.FlushCnt, 32'd0);
    rst_n = 1'b1;
    ctl(1, 1, 0, 1, 0, 32'h0);
    bus.CtrlD = 10'd0;
    tick;
    tick;
    tick;
    chk("cnt_stall_pcf", bus.PCF, 32'h0);
    chk("cnt_stall_stallcnt", bus.StallCnt, SC3);
    chk("cnt_stall_flushcnt", bus.FlushCnt, 32'd0);
    ctl(0, 0, 0, 0, 0, 32'h0);
    bus.InstrF = IA;
    tick;
    chk("first_fetch_pcd", bus.PCD, 32'h0);
    chk("first_fetch_pcf", bus.PCF, 32'h4);
    chk("first_fetch_validd", {31'd0, bus.ValidD}, 32'd1);
    ctl(0, 0, 1, 1, 1, 32'h40);
    tick;
    chk("cnt_redir_pcf", bus.PCF, 32'h40);
    chk("cnt_redir_stallcnt", bus.StallCnt, SC3);
    chk("cnt_redir_flushcnt", bus.FlushCnt, FC3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
